// File: rtl/cbfp_pkg.sv
// Shared CBFP definitions: scale-factor buffer geometry and scheduler state encoding.
`default_nettype none

package cbfp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } sf_sched_state_e;

  localparam int CBFP1_SF_DEPTH = 512;
  localparam int CBFP1_SF_SLOT  = 32;
  localparam int CBFP1_SF_SLOTS = CBFP1_SF_DEPTH / CBFP1_SF_SLOT;

endpackage

`default_nettype wire

// File: rtl/sf_occ_counter.sv
// Up/down counter with full/empty flags; simultaneous inc+dec holds the count.
// WRAP=1 turns it into a free-running modulo-2^W pointer mirror.
`default_nettype none

module sf_occ_counter #(
  parameter int W    = 5,
  parameter int MAX  = 16,
  parameter bit WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam logic [W-1:0] MAX_L = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      if (WRAP || (cnt_q != MAX_L)) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (WRAP || (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign nxt_o   = cnt_d;
  assign full_o  = (cnt_q == MAX_L);
  assign empty_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/cbfp1_sf_sched.sv
// CBFP1 scale-factor buffer scheduler: push/pop strobes, slot mirrors, start threshold.
// Optional CBFP1_SF_SCHED_STATS_EN adds frame_count and stall_count outputs.
`default_nettype none

module cbfp1_sf_sched
  import cbfp_pkg::*;
#(
  parameter int DEPTH        = CBFP1_SF_DEPTH,
  parameter int SLOT         = CBFP1_SF_SLOT,
  parameter int SLOTS        = DEPTH / SLOT,
  parameter int SLOT_W       = 5,
  parameter int START_THRESH = 16,
  parameter int FRAME_SLOTS  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              push2,
  input  logic              sf_ready,
  output logic              pop,
  output logic              sf_valid,
  output logic              frame_done,
  output logic [SLOT_W-1:0] occ,
  output logic              busy,
  output logic              ovf_err
`ifdef CBFP1_SF_SCHED_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FC_W  = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;
  localparam logic [SLOT_W-1:0] THRESH_L   = SLOT_W'(START_THRESH);
  localparam logic [FC_W-1:0]   FRAME_LAST = FC_W'(FRAME_SLOTS - 1);

  sf_sched_state_e   state_q, state_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              sf_valid_q;
  logic              ovf_err_q;

  logic [SLOT_W-1:0] w_occ, w_occ_nxt;
  logic              w_full, w_empty;
  logic [PTR_W-1:0]  w_wr_slot, w_rd_slot;
  logic [PTR_W-1:0]  w_wr_nxt, w_rd_nxt;
  logic              w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
  logic              w_unused;

  sf_occ_counter #(.W(SLOT_W), .MAX(SLOTS), .WRAP(1'b0)) u_occ (
    .clk(clk), .rstn(rstn), .inc_i(push2), .dec_i(pop),
    .cnt_o(w_occ), .nxt_o(w_occ_nxt), .full_o(w_full), .empty_o(w_empty)
  );

  // Slot-granular mirrors of the buffer's 9-bit pointers (advance by SLOT entries).
  sf_occ_counter #(.W(PTR_W), .MAX(SLOTS - 1), .WRAP(1'b1)) u_wr_slot (
    .clk(clk), .rstn(rstn), .inc_i(push2), .dec_i(1'b0),
    .cnt_o(w_wr_slot), .nxt_o(w_wr_nxt), .full_o(w_wr_full), .empty_o(w_wr_empty)
  );

  sf_occ_counter #(.W(PTR_W), .MAX(SLOTS - 1), .WRAP(1'b1)) u_rd_slot (
    .clk(clk), .rstn(rstn), .inc_i(pop), .dec_i(1'b0),
    .cnt_o(w_rd_slot), .nxt_o(w_rd_nxt), .full_o(w_rd_full), .empty_o(w_rd_empty)
  );

  assign w_unused = ^{w_wr_slot, w_rd_slot, w_wr_nxt, w_rd_nxt,
                      w_wr_full, w_wr_empty, w_rd_full, w_rd_empty};

  assign pop        = (state_q == DRAIN) && !w_empty && sf_ready;
  assign in_ready   = !w_full || pop;
  assign push2      = in_valid && in_ready;
  assign frame_done = pop && (frame_cnt_q == FRAME_LAST);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (push2) state_d = (w_occ_nxt >= THRESH_L) ? DRAIN : FILL;
      end
      FILL: begin
        if (w_occ_nxt >= THRESH_L) state_d = DRAIN;
      end
      DRAIN: begin
        if (frame_done) begin
          frame_cnt_d = '0;
          if ((w_occ_nxt == '0) && !push2) state_d = IDLE;
          else if (w_occ_nxt < THRESH_L)   state_d = FILL;
        end else if (pop) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      sf_valid_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      sf_valid_q  <= pop;
      if (in_valid && w_full && !pop) ovf_err_q <= 1'b1;
    end
  end

  assign sf_valid = sf_valid_q;
  assign ovf_err  = ovf_err_q;
  assign occ      = w_occ;
  assign busy     = (state_q != IDLE);

`ifdef CBFP1_SF_SCHED_STATS_EN
  logic [15:0] frame_count_q;
  logic [15:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (frame_done) frame_count_q <= frame_count_q + 16'd1;
      if ((state_q == DRAIN) && !w_empty && !sf_ready && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
  assign stall_count = stall_count_q;
`endif

  a_occ_range: assert property (@(posedge clk) disable iff (!rstn) w_occ <= SLOT_W'(SLOTS));

endmodule

`default_nettype wire
